// File: rtl/cam_ddr_write_arbiter_if.sv
// DDR write-port bundle between the camera write arbiter and the DDR controller.
// The arbiter drives the request, address, length and data; the controller answers
// with per-word data requests and a finish pulse.
interface cam_ddr_write_arbiter_if #(
   parameter int ADDR_W = 25
);
   logic              wr_burst_req;
   logic [9:0]        wr_burst_len;
   logic [ADDR_W-1:0] wr_burst_addr;
   logic              wr_burst_data_req;
   logic [31:0]       wr_burst_data;
   logic              wr_burst_finish;

   modport master (
      output wr_burst_req,
      output wr_burst_len,
      output wr_burst_addr,
      output wr_burst_data,
      input  wr_burst_data_req,
      input  wr_burst_finish
   );

   modport slave (
      input  wr_burst_req,
      input  wr_burst_len,
      input  wr_burst_addr,
      input  wr_burst_data,
      output wr_burst_data_req,
      output wr_burst_finish
   );
endinterface

// File: rtl/cam_ddr_write_arbiter.sv
// Round-robin DDR write-burst scheduler for two camera capture FIFOs.
// Each channel writes into its own double-buffered frame store; a vsync rising
// edge starts a new frame in the other bank and publishes the finished bank
// as the read bank for the display side.
module cam_ddr_write_arbiter #(
   parameter int BURST_LEN   = 64,
   parameter int FRAME_WORDS = 460800,
   parameter int CH0_BASE    = 0,
   parameter int CH1_BASE    = 1048576,
   parameter int ADDR_W      = 25,
   parameter int FIFO_AW     = 10
) (
   input  logic                   ddr_clk,
   input  logic                   rst_n,
   input  logic                   ch0_vsync,
   input  logic                   ch1_vsync,
   input  logic [FIFO_AW-1:0]     ch0_fifo_usedw,
   input  logic [FIFO_AW-1:0]     ch1_fifo_usedw,
   input  logic [31:0]            ch0_fifo_q,
   input  logic [31:0]            ch1_fifo_q,
   output logic                   ch0_fifo_rden,
   output logic                   ch1_fifo_rden,
   cam_ddr_write_arbiter_if.master ddr,
   output logic                   ch0_read_bank,
   output logic                   ch1_read_bank
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

   state_t            r_state;
   logic [1:0]        r_sync1;
   logic [1:0]        r_sync2;
   logic [1:0]        r_syncPrev;
   logic [1:0]        r_wb;
   logic [1:0]        r_readBank;
   logic [1:0]        r_pend;
   logic [31:0]       r_ptr [2];
   logic              r_grant;
   logic              r_lastGrant;
   logic              r_req;
   logic [ADDR_W-1:0] r_addr;

   logic [1:0]         w_vsync;
   logic [1:0]         w_fs;
   logic [1:0]         w_ready;
   logic [FIFO_AW-1:0] w_usedw [2];
   logic [ADDR_W-1:0]  w_addr [2];
   logic               w_pick;
   logic               w_inData;

   assign w_vsync   = {ch1_vsync, ch0_vsync};
   assign w_usedw[0] = ch0_fifo_usedw;
   assign w_usedw[1] = ch1_fifo_usedw;
   assign w_fs      = r_sync2 & ~r_syncPrev;

   // Readiness and next-burst address per channel. A channel whose frame start
   // is being applied this cycle is held off so its burst uses the new bank.
   always_comb begin
      w_ready   = 2'b00;
      w_addr[0] = '0;
      w_addr[1] = '0;
      for (int c = 0; c < 2; c++) begin
         w_ready[c] = (32'(w_usedw[c]) >= 32'(BURST_LEN)) &&
                      ((r_ptr[c] + 32'(BURST_LEN)) <= 32'(FRAME_WORDS)) &&
                      !w_fs[c];
         w_addr[c]  = ADDR_W'(((c == 0) ? 32'(CH0_BASE) : 32'(CH1_BASE)) +
                              (r_wb[c] ? 32'(FRAME_WORDS) : 32'd0) + r_ptr[c]);
      end
   end

   // On a tie the channel not served last wins; otherwise the only ready one.
   assign w_pick   = (&w_ready) ? ~r_lastGrant : w_ready[1];

   // The first data request can arrive while still in REQ, so that cycle pops too.
   assign w_inData = (r_state == S_REQ) || (r_state == S_DATA);

   assign ch0_fifo_rden = w_inData && ddr.wr_burst_data_req && !r_grant;
   assign ch1_fifo_rden = w_inData && ddr.wr_burst_data_req &&  r_grant;

   assign ddr.wr_burst_req  = r_req;
   assign ddr.wr_burst_len  = 10'(BURST_LEN);
   assign ddr.wr_burst_addr = r_addr;
   assign ddr.wr_burst_data = (r_state == S_DATA) ? (r_grant ? ch1_fifo_q : ch0_fifo_q) : 32'd0;

   assign ch0_read_bank = r_readBank[0];
   assign ch1_read_bank = r_readBank[1];

   // Two-flop vsync synchroniser plus a delayed copy for rising-edge detection.
   always_ff @(posedge ddr_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 2'b00;
         r_sync2    <= 2'b00;
         r_syncPrev <= 2'b00;
      end else begin
         r_sync1    <= w_vsync;
         r_sync2    <= r_sync1;
         r_syncPrev <= r_sync2;
      end
   end

   // Burst FSM together with the per-channel frame pointers and bank flags.
   always_ff @(posedge ddr_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_grant     <= 1'b0;
         r_lastGrant <= 1'b1;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_wb        <= 2'b00;
         r_readBank  <= 2'b11;
         r_pend      <= 2'b00;
         r_ptr[0]    <= 32'd0;
         r_ptr[1]    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_ready) begin
                  r_grant <= w_pick;
                  r_addr  <= w_addr[w_pick];
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (ddr.wr_burst_data_req) begin
                  r_req   <= 1'b0;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (ddr.wr_burst_finish) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_lastGrant <= r_grant;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         for (int c = 0; c < 2; c++) begin
            if (r_state == S_DONE && r_grant == c[0]) begin
               if (r_pend[c] || w_fs[c]) begin
                  r_ptr[c]      <= 32'd0;
                  r_readBank[c] <= r_wb[c];
                  r_wb[c]       <= ~r_wb[c];
                  r_pend[c]     <= 1'b0;
               end else begin
                  r_ptr[c] <= r_ptr[c] + 32'(BURST_LEN);
               end
            end else if (w_fs[c]) begin
               if (r_state != S_IDLE && r_grant == c[0]) begin
                  r_pend[c] <= 1'b1;
               end else begin
                  r_ptr[c]      <= 32'd0;
                  r_readBank[c] <= r_wb[c];
                  r_wb[c]       <= ~r_wb[c];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_ddr_write_arbiter.sv
// Self-checking bench for cam_ddr_write_arbiter. A frame-store model tracks
// pointer, bank and read bank per channel from the scheduling rules; a DDR
// controller model issues randomly spaced data requests and checks every word.
module tb_cam_ddr_write_arbiter;

   localparam int BL   = 64;
   localparam int FW   = 192;
   localparam int CH0B = 0;
   localparam int CH1B = 1048576;
   localparam int AW   = 25;
   localparam int FAW  = 10;

   logic           ddr_clk = 1'b0;
   logic           rst_n;
   logic           ch0_vsync, ch1_vsync;
   logic [FAW-1:0] ch0_fifo_usedw, ch1_fifo_usedw;
   logic [31:0]    ch0_fifo_q, ch1_fifo_q;
   logic           ch0_fifo_rden, ch1_fifo_rden;
   logic           ch0_read_bank, ch1_read_bank;

   cam_ddr_write_arbiter_if #(.ADDR_W(AW)) ddr();

   cam_ddr_write_arbiter #(
      .BURST_LEN(BL), .FRAME_WORDS(FW), .CH0_BASE(CH0B), .CH1_BASE(CH1B),
      .ADDR_W(AW), .FIFO_AW(FAW)
   ) dut (
      .ddr_clk(ddr_clk), .rst_n(rst_n),
      .ch0_vsync(ch0_vsync), .ch1_vsync(ch1_vsync),
      .ch0_fifo_usedw(ch0_fifo_usedw), .ch1_fifo_usedw(ch1_fifo_usedw),
      .ch0_fifo_q(ch0_fifo_q), .ch1_fifo_q(ch1_fifo_q),
      .ch0_fifo_rden(ch0_fifo_rden), .ch1_fifo_rden(ch1_fifo_rden),
      .ddr(ddr),
      .ch0_read_bank(ch0_read_bank), .ch1_read_bank(ch1_read_bank)
   );

   // Free-running DDR clock.
   always #5 ddr_clk = ~ddr_clk;

   int errors = 0;
   int checks = 0;

   // Frame-store reference model.
   int mPtr [2];
   bit mWb  [2];
   bit mRb  [2];
   bit mPend[2];
   int mLast;

   // DDR controller / FIFO model state.
   bit          active;
   int          curCh;
   int          issued, captured, pops;
   bit          capPending;
   int          bursts, starts;
   bit          popNext[2];
   logic [31:0] fifoExp0[$];
   logic [31:0] fifoExp1[$];
   int          vsHold[2];
   bit          trigArmed;
   int          trigCh, trigWords;

   function automatic bit mReady(int c);
      int u;
      u = (c == 0) ? int'(ch0_fifo_usedw) : int'(ch1_fifo_usedw);
      return (u >= BL) && (mPtr[c] + BL <= FW);
   endfunction

   function automatic int mAddr(int c);
      longint a;
      a = longint'((c == 0) ? CH0B : CH1B) + longint'(mWb[c] ? FW : 0) + longint'(mPtr[c]);
      return int'(a % (longint'(1) << AW));
   endfunction

   task automatic apply_frame(int c);
      mPtr[c] = 0;
      mRb[c]  = mWb[c];
      mWb[c]  = ~mWb[c];
   endtask

   task automatic raise_vsync(int c);
      if (c == 0) ch0_vsync = 1'b1; else ch1_vsync = 1'b1;
      vsHold[c] = 4;
      if (active && curCh == c) mPend[c] = 1'b1;
      else apply_frame(c);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         mPtr[c] = 0; mWb[c] = 1'b0; mRb[c] = 1'b1; mPend[c] = 1'b0; popNext[c] = 1'b0;
      end
      mLast = 1;
      active = 1'b0; capPending = 1'b0; issued = 0; captured = 0; pops = 0;
      trigArmed = 1'b0;
      fifoExp0.delete();
      fifoExp1.delete();
   endtask

   // One clock of FIFO, vsync and DDR-controller behaviour plus output checks.
   task automatic cycle();
      logic [31:0] w, expW, gotW;
      bit          haveW, r0, r1, expR;
      logic        obsR;
      int          ch;
      @(negedge ddr_clk);
      if (popNext[0]) begin w = $urandom; ch0_fifo_q = w; fifoExp0.push_back(w); popNext[0] = 1'b0; end
      if (popNext[1]) begin w = $urandom; ch1_fifo_q = w; fifoExp1.push_back(w); popNext[1] = 1'b0; end
      for (int c = 0; c < 2; c++) begin
         if (vsHold[c] > 0) begin
            vsHold[c]--;
            if (vsHold[c] == 0) begin
               if (c == 0) ch0_vsync = 1'b0; else ch1_vsync = 1'b0;
            end
         end
      end
      ddr.wr_burst_finish   = 1'b0;
      ddr.wr_burst_data_req = 1'b0;
      if (rst_n === 1'b1 && active) begin
         if (issued == BL && captured == BL) begin
            ddr.wr_burst_finish = 1'b1;
            checks++;
            if (pops != BL) begin
               errors++;
               $display("[TB] FAIL pop_count ch%0d: got %0d pops, expected %0d", curCh, pops, BL);
            end
            mPtr[curCh] += BL;
            if (mPend[curCh]) begin apply_frame(curCh); mPend[curCh] = 1'b0; end
            mLast  = curCh;
            active = 1'b0;
            bursts++;
         end else if (issued < BL && $urandom_range(0, 3) != 0) begin
            ddr.wr_burst_data_req = 1'b1;
            issued++;
         end
      end
      #1;
      if (rst_n === 1'b1) begin
         if (capPending) begin
            haveW = 1'b0; expW = 32'd0;
            if (curCh == 0 && fifoExp0.size() > 0) begin expW = fifoExp0.pop_front(); haveW = 1'b1; end
            if (curCh == 1 && fifoExp1.size() > 0) begin expW = fifoExp1.pop_front(); haveW = 1'b1; end
            gotW = ddr.wr_burst_data;
            checks++;
            if (!haveW || gotW !== expW) begin
               errors++;
               $display("[TB] FAIL burst_data ch%0d word %0d: got %h, expected %h (word available=%0d)",
                        curCh, captured, gotW, expW, haveW);
            end
            captured++;
         end
         capPending = ddr.wr_burst_data_req && active;
         for (int c = 0; c < 2; c++) begin
            obsR = (c == 0) ? ch0_fifo_rden : ch1_fifo_rden;
            expR = active && ddr.wr_burst_data_req && (curCh == c);
            checks++;
            if (obsR !== expR) begin
               errors++;
               $display("[TB] FAIL rden ch%0d: got %b, expected %b", c, obsR, expR);
            end
            if (obsR === 1'b1) begin
               popNext[c] = 1'b1;
               if (c == curCh) pops++;
            end
         end
         if (ddr.wr_burst_req === 1'b1 && !active) begin
            r0 = mReady(0);
            r1 = mReady(1);
            if (r0 && r1) ch = 1 - mLast;
            else if (r0)  ch = 0;
            else if (r1)  ch = 1;
            else          ch = -1;
            checks++;
            if (ch < 0) begin
               errors++;
               $display("[TB] FAIL unexpected_req: got request at addr %0d, expected no channel ready", ddr.wr_burst_addr);
               ch = 0;
            end else if (ddr.wr_burst_addr !== AW'(mAddr(ch))) begin
               errors++;
               $display("[TB] FAIL burst_addr ch%0d: got %0d, expected %0d", ch, ddr.wr_burst_addr, mAddr(ch));
            end
            curCh = ch; active = 1'b1; issued = 0; captured = 0; pops = 0;
            fifoExp0.delete();
            fifoExp1.delete();
            starts++;
         end
         if (trigArmed && active && captured >= trigWords) begin
            raise_vsync(trigCh);
            trigArmed = 1'b0;
         end
      end else begin
         capPending = 1'b0;
      end
   endtask

   task automatic wait_cycles(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_bursts(int n, int budget, string name);
      int target, k;
      target = bursts + n;
      k = 0;
      while (bursts < target && k < budget) begin cycle(); k++; end
      checks++;
      if (bursts < target) begin
         errors++;
         $display("[TB] FAIL %s_timeout: got %0d bursts, expected %0d within %0d cycles", name, bursts - (target - n), n, budget);
      end
   endtask

   task automatic check_banks(string name);
      checks++;
      if (ch0_read_bank !== mRb[0]) begin
         errors++;
         $display("[TB] FAIL %s_rb0: got %b, expected %b", name, ch0_read_bank, mRb[0]);
      end
      checks++;
      if (ch1_read_bank !== mRb[1]) begin
         errors++;
         $display("[TB] FAIL %s_rb1: got %b, expected %b", name, ch1_read_bank, mRb[1]);
      end
   endtask

   // Power-on reset values of every output.
   task automatic test_reset();
      rst_n = 1'b0;
      ch0_vsync = 1'b0; ch1_vsync = 1'b0;
      ch0_fifo_usedw = '0; ch1_fifo_usedw = '0;
      ch0_fifo_q = 32'd0; ch1_fifo_q = 32'd0;
      ddr.wr_burst_data_req = 1'b0; ddr.wr_burst_finish = 1'b0;
      vsHold[0] = 0; vsHold[1] = 0;
      bursts = 0; starts = 0; curCh = 0;
      model_reset();
      wait_cycles(3);
      checks++; if (ddr.wr_burst_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, expected 0", ddr.wr_burst_req); end
      checks++; if (ddr.wr_burst_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, expected 0", ddr.wr_burst_addr); end
      checks++; if (ddr.wr_burst_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 0", ddr.wr_burst_data); end
      checks++; if (ddr.wr_burst_len !== 10'd64) begin errors++; $display("[TB] FAIL burst_len: got %0d, expected 64", ddr.wr_burst_len); end
      checks++; if (ch0_fifo_rden !== 1'b0 || ch1_fifo_rden !== 1'b0) begin errors++; $display("[TB] FAIL reset_rden: got %b%b, expected 00", ch1_fifo_rden, ch0_fifo_rden); end
      check_banks("reset");
      rst_n = 1'b1;
      wait_cycles(4);
      check_banks("after_reset");
      checks++; if (ddr.wr_burst_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b, expected 0", ddr.wr_burst_req); end
   endtask

   // Channel 0 alone after a frame start: bursts at FW then FW+BL.
   task automatic test_single_channel();
      raise_vsync(0);
      wait_cycles(8);
      check_banks("single_fs");
      ch0_fifo_usedw = 10'd64;
      run_bursts(2, 500, "single");
      ch0_fifo_usedw = '0;
      wait_cycles(4);
   endtask

   // Both channels ready: grants alternate between them.
   task automatic test_alternate();
      int firstCh;
      raise_vsync(0);
      raise_vsync(1);
      wait_cycles(8);
      check_banks("alt_fs");
      ch0_fifo_usedw = 10'd1000;
      ch1_fifo_usedw = 10'd1000;
      firstCh = 1 - mLast;
      run_bursts(4, 1000, "alternate");
      ch0_fifo_usedw = '0;
      ch1_fifo_usedw = '0;
      checks++;
      if (mLast != 1 - firstCh) begin
         errors++;
         $display("[TB] FAIL alternate_last: got last grant %0d, expected %0d", mLast, 1 - firstCh);
      end
      wait_cycles(4);
   endtask

   // Frame fill: exactly FW/BL bursts, then silence until the next vsync.
   task automatic test_frame_fill();
      int s0;
      raise_vsync(0);
      wait_cycles(8);
      ch0_fifo_usedw = 10'd1000;
      s0 = starts;
      run_bursts(3, 900, "fill");
      wait_cycles(300);
      checks++;
      if (starts - s0 != 3) begin
         errors++;
         $display("[TB] FAIL fill_count: got %0d bursts, expected 3", starts - s0);
      end
      check_banks("fill_full");
      raise_vsync(0);
      run_bursts(1, 400, "refill");
      ch0_fifo_usedw = '0;
      wait_cycles(6);
      check_banks("refill");
   endtask

   // Frame start on the granted channel mid-burst is deferred to burst end.
   task automatic test_vsync_granted();
      ch0_fifo_usedw = 10'd64;
      trigArmed = 1'b1; trigCh = 0; trigWords = 8;
      run_bursts(2, 800, "granted_vsync");
      ch0_fifo_usedw = '0;
      wait_cycles(6);
      check_banks("granted_vsync");
   endtask

   // Vsync on the idle channel mid-burst, then reset in the middle of DATA.
   task automatic test_simultaneous();
      int k;
      ch0_fifo_usedw = 10'd64;
      trigArmed = 1'b1; trigCh = 1; trigWords = 5;
      k = 0;
      while (!(active && captured >= 30) && k < 400) begin cycle(); k++; end
      checks++;
      if (!(active && captured >= 30)) begin
         errors++;
         $display("[TB] FAIL sim_timeout: got %0d words, expected 30 within 400 cycles", captured);
      end
      check_banks("sim_vsync");
      rst_n = 1'b0;
      #1;
      checks++; if (ddr.wr_burst_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req: got %b, expected 0", ddr.wr_burst_req); end
      checks++; if (ch0_fifo_rden !== 1'b0 || ch1_fifo_rden !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rden: got %b%b, expected 00", ch1_fifo_rden, ch0_fifo_rden); end
      checks++; if (ddr.wr_burst_addr !== '0) begin errors++; $display("[TB] FAIL midreset_addr: got %0d, expected 0", ddr.wr_burst_addr); end
      checks++; if (ddr.wr_burst_data !== 32'd0) begin errors++; $display("[TB] FAIL midreset_data: got %h, expected 0", ddr.wr_burst_data); end
      model_reset();
      check_banks("midreset");
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(4);
      run_bursts(1, 400, "post_reset");
      ch0_fifo_usedw = '0;
      wait_cycles(4);
      check_banks("post_reset");
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_alternate();
      test_frame_fill();
      test_vsync_granted();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
